// File: rtl/rank_encoder_pkg.sv
// Shared types for the rank-order pixel encoder.
package rank_encoder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    EMIT,
    NEXT_LEVEL,
    FINISH
  } state_t;

endpackage

// File: rtl/rank_encoder.sv
// Rank-order encoder: emits pixel indexes level by level, brightest or darkest first,
// with equal-intensity pixels in increasing index order.
module rank_encoder
  import rank_encoder_pkg::*;
#(
  parameter int IMAGE_SIZE      = 5,
  parameter int PIXEL_MAX_VALUE = 10,
  parameter int PIXEL_BITS      = (PIXEL_MAX_VALUE > 1) ? $clog2(PIXEL_MAX_VALUE) : 1,
  parameter int IDX_BITS        = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1,
  parameter int CNT_BITS        = $clog2(IMAGE_SIZE + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [PIXEL_BITS-1:0] image [0:IMAGE_SIZE-1],
  input  logic                  start,
  input  logic                  ascending,
  input  logic [PIXEL_BITS-1:0] threshold,
  input  logic                  abort,
  input  logic                  idx_ready,
  output logic                  idx_valid,
  output logic [IDX_BITS-1:0]   idx_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_BITS-1:0]   spike_count
);

  localparam logic [PIXEL_BITS-1:0] MAX_LVL  = PIXEL_BITS'(PIXEL_MAX_VALUE - 1);
  localparam logic [PIXEL_BITS:0]   LVL_LIM  = (PIXEL_BITS + 1)'(PIXEL_MAX_VALUE);
  localparam logic [IDX_BITS-1:0]   LAST_PID = IDX_BITS'(IMAGE_SIZE - 1);
  localparam logic [CNT_BITS-1:0]   FULL_CNT = CNT_BITS'(IMAGE_SIZE);

  state_t                state_reg, state_next;
  logic [PIXEL_BITS-1:0] level_reg, level_next;
  logic [IDX_BITS-1:0]   pid_reg, pid_next;
  logic                  asc_reg, asc_next;
  logic [PIXEL_BITS-1:0] thr_reg, thr_next;
  logic [CNT_BITS-1:0]   cnt_reg, cnt_next;
  logic [PIXEL_BITS-1:0] image_reg [0:IMAGE_SIZE-1];
  logic                  load_en;
  logic [IMAGE_SIZE-1:0] match_vec;
  logic [CNT_BITS-1:0]   cnt_inc;
  logic                  final_level;

  // Per-pixel comparison against the level currently being scanned.
  generate
    for (genvar gi = 0; gi < IMAGE_SIZE; gi++) begin : g_match
      assign match_vec[gi] = (image_reg[gi] == level_reg);
    end
  endgenerate

  assign cnt_inc     = cnt_reg + 1'b1;
  assign final_level = asc_reg ? (level_reg == MAX_LVL) : (level_reg == thr_reg);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      level_reg <= '0;
      pid_reg   <= '0;
      asc_reg   <= 1'b0;
      thr_reg   <= '0;
      cnt_reg   <= '0;
      for (int i = 0; i < IMAGE_SIZE; i++) image_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      pid_reg   <= pid_next;
      asc_reg   <= asc_next;
      thr_reg   <= thr_next;
      cnt_reg   <= cnt_next;
      if (load_en) begin
        for (int i = 0; i < IMAGE_SIZE; i++) image_reg[i] <= image[i];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    pid_next   = pid_reg;
    asc_next   = asc_reg;
    thr_next   = thr_reg;
    cnt_next   = cnt_reg;
    load_en    = 1'b0;

    // Abort outranks everything, including a transfer in the same cycle.
    if (abort && state_reg != IDLE) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            load_en    = 1'b1;
            asc_next   = ascending;
            thr_next   = threshold;
            pid_next   = '0;
            cnt_next   = '0;
            level_next = ascending ? threshold : MAX_LVL;
            state_next = ({1'b0, threshold} >= LVL_LIM) ? FINISH : SCAN;
          end
        end
        SCAN: begin
          if (match_vec[pid_reg]) begin
            state_next = EMIT;
          end else if (pid_reg == LAST_PID) begin
            state_next = NEXT_LEVEL;
          end else begin
            pid_next = pid_reg + 1'b1;
          end
        end
        EMIT: begin
          if (idx_ready) begin
            cnt_next = cnt_inc;
            if (cnt_inc == FULL_CNT) begin
              state_next = FINISH;
            end else if (pid_reg == LAST_PID) begin
              state_next = NEXT_LEVEL;
            end else begin
              pid_next   = pid_reg + 1'b1;
              state_next = SCAN;
            end
          end
        end
        NEXT_LEVEL: begin
          if (final_level) begin
            state_next = FINISH;
          end else begin
            level_next = asc_reg ? level_reg + 1'b1 : level_reg - 1'b1;
            pid_next   = '0;
            state_next = SCAN;
          end
        end
        FINISH:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign idx_valid   = (state_reg == EMIT);
  assign idx_data    = (state_reg == EMIT) ? pid_reg : '0;
  assign busy        = (state_reg == SCAN) || (state_reg == EMIT) || (state_reg == NEXT_LEVEL);
  assign done        = (state_reg == FINISH);
  assign spike_count = cnt_reg;

endmodule

// File: tb/tb_rank_encoder.sv
// Scoreboard bench for rank_encoder: directed encodes with hand-computed index orders.
module tb_rank_encoder;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] img [0:4];
  logic       start = 1'b0;
  logic       ascending = 1'b0;
  logic [3:0] threshold = 4'd0;
  logic       abort = 1'b0;
  logic       idx_ready = 1'b1;
  logic       idx_valid;
  logic [2:0] idx_data;
  logic       busy;
  logic       done;
  logic [2:0] spike_count;

  int errors = 0;
  int checks = 0;
  int sb_q[$];
  int xfer_cnt = 0;
  int done_cnt = 0;
  bit rand_mode = 1'b0;

  rank_encoder dut (
    .CLK(CLK), .RST(RST), .image(img), .start(start), .ascending(ascending),
    .threshold(threshold), .abort(abort), .idx_ready(idx_ready),
    .idx_valid(idx_valid), .idx_data(idx_data), .busy(busy), .done(done),
    .spike_count(spike_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Random backpressure, applied just after each rising edge.
  always @(posedge CLK) begin
    #1;
    if (rand_mode) idx_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on every transfer, checks hold-while-stalled.
  initial begin
    bit       stall_pend = 1'b0;
    logic [2:0] held = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) begin
          chk("stall_valid_held", int'(idx_valid), 1);
          chk("stall_data_held", int'(idx_data), int'(held));
        end
        if (idx_valid && idx_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_transfer", int'(idx_data), -1);
          end else begin
            chk("idx_data", int'(idx_data), sb_q.pop_front());
          end
          xfer_cnt++;
          stall_pend = 1'b0;
        end else if (idx_valid) begin
          stall_pend = 1'b1;
          held = idx_data;
        end else begin
          stall_pend = 1'b0;
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic set_image();
    img[0] = 4'd3; img[1] = 4'd9; img[2] = 4'd9; img[3] = 4'd0; img[4] = 4'd5;
  endtask

  task automatic pulse_start(input logic asc, input logic [3:0] thr);
    ascending = asc;
    threshold = thr;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    // Scramble the live input; the latched copy must be used.
    for (int k = 0; k < 5; k++) img[k] = 4'd7;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      if (done) begin seen = 1'b1; break; end
    end
    chk({name, "_done_seen"}, int'(seen), 1);
    @(posedge CLK); #1;
  endtask

  task automatic run_encode(input string name, input logic asc, input logic [3:0] thr,
                            input int exp_seq[5], input int n, input int budget, input bit rnd);
    set_image();
    for (int i = 0; i < n; i++) sb_q.push_back(exp_seq[i]);
    idx_ready = 1'b1;
    rand_mode = rnd;
    pulse_start(asc, thr);
    wait_done(name, budget);
    rand_mode = 1'b0;
    idx_ready = 1'b1;
    chk({name, "_spike_count"}, int'(spike_count), n);
    chk({name, "_queue_empty"}, sb_q.size(), 0);
    @(posedge CLK); #1;
    chk({name, "_count_hold"}, int'(spike_count), n);
    chk({name, "_idle_busy"}, int'(busy), 0);
    sb_q.delete();
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (idx_valid) begin seen = 1'b1; break; end
    end
    chk({name, "_valid_seen"}, int'(seen), 1);
    @(posedge CLK); #1;
  endtask

  initial begin
    int seq_desc[5] = '{1, 2, 4, 0, 3};
    int seq_asc[5]  = '{3, 0, 4, 1, 2};
    int dc;
    int base;
    bit got;

    set_image();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_idx_valid", int'(idx_valid), 0);
    chk("rst_idx_data", int'(idx_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_spike_count", int'(spike_count), 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    run_encode("desc_th0", 1'b0, 4'd0, seq_desc, 5, 200, 1'b0);
    run_encode("asc_th0", 1'b1, 4'd0, seq_asc, 5, 200, 1'b0);
    run_encode("desc_th4", 1'b0, 4'd4, seq_desc, 3, 200, 1'b0);
    run_encode("th10", 1'b0, 4'd10, seq_desc, 0, 2, 1'b0);
    run_encode("asc_th10", 1'b1, 4'd10, seq_asc, 0, 2, 1'b0);
    run_encode("rand_ready", 1'b0, 4'd0, seq_desc, 5, 600, 1'b1);

    // Abort right after the second transfer.
    set_image();
    sb_q.push_back(1);
    sb_q.push_back(2);
    base = xfer_cnt;
    idx_ready = 1'b1;
    pulse_start(1'b0, 4'd0);
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (xfer_cnt >= base + 2) begin got = 1'b1; break; end
    end
    chk("abort_two_xfers", int'(got), 1);
    @(posedge CLK); #1;
    abort = 1'b1;
    dc = done_cnt;
    @(posedge CLK); #1;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_idx_valid", int'(idx_valid), 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("abort_no_done", done_cnt, dc);
    chk("abort_spike_count", int'(spike_count), 2);
    chk("abort_queue_empty", sb_q.size(), 0);
    sb_q.delete();
    run_encode("after_abort", 1'b0, 4'd0, seq_desc, 5, 200, 1'b0);

    // Start while busy must be ignored.
    set_image();
    for (int i = 0; i < 5; i++) sb_q.push_back(seq_desc[i]);
    idx_ready = 1'b0;
    pulse_start(1'b0, 4'd0);
    wait_valid("busy_start");
    ascending = 1'b1;
    threshold = 4'd10;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    ascending = 1'b0;
    threshold = 4'd0;
    chk("busy_start_busy", int'(busy), 1);
    idx_ready = 1'b1;
    wait_done("busy_start", 200);
    chk("busy_start_spike_count", int'(spike_count), 5);
    chk("busy_start_queue_empty", sb_q.size(), 0);
    sb_q.delete();

    // Reset in the middle of EMIT.
    set_image();
    idx_ready = 1'b0;
    pulse_start(1'b0, 4'd0);
    wait_valid("mid_rst");
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    idx_ready = 1'b1;
    chk("mid_rst_idx_valid", int'(idx_valid), 0);
    chk("mid_rst_idx_data", int'(idx_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_spike_count", int'(spike_count), 0);
    run_encode("after_rst", 1'b1, 4'd0, seq_asc, 5, 200, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rank_encoder.md
RANK_ENCODER -- requirements
Module: rank_encoder

Interface
REQ-001 Parameter IMAGE_SIZE, default 5, number of pixels per image.
REQ-002 Parameter PIXEL_MAX_VALUE, default 10, number of intensity levels (valid pixel values 0..PIXEL_MAX_VALUE-1).
REQ-003 Parameter PIXEL_BITS, default max(1,$clog2(PIXEL_MAX_VALUE)), pixel and level width.
REQ-004 Parameter IDX_BITS, default max(1,$clog2(IMAGE_SIZE)), index width; CNT_BITS = $clog2(IMAGE_SIZE+1), count width.
REQ-005 CLK  in  1  single clock; all logic on posedge CLK.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 image  in  PIXEL_BITS x IMAGE_SIZE  unpacked input image [0:IMAGE_SIZE-1].
REQ-008 start  in  1  request a new encode; sampled only in IDLE.
REQ-009 ascending  in  1  order mode, sampled with start: 0 = brightest first, 1 = darkest first.
REQ-010 threshold  in  PIXEL_BITS  minimum emitted intensity, sampled with start.
REQ-011 abort  in  1  terminate current encode.
REQ-012 idx_ready  in  1  downstream accepts idx_data.
REQ-013 idx_valid  out  1  idx_data holds a valid pixel index.
REQ-014 idx_data  out  IDX_BITS  emitted pixel index.
REQ-015 busy  out  1  encode in progress.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 spike_count  out  CNT_BITS  indexes emitted in current/last encode.

Function
REQ-018 FSM states: IDLE, SCAN, EMIT, NEXT_LEVEL, FINISH.
REQ-019 IDLE, start=1: latch image, ascending, threshold into internal registers; pid=0; spike_count=0; level = threshold if ascending else PIXEL_MAX_VALUE-1; next state SCAN; busy=1 from next cycle. Image input changes after this edge have no effect.
REQ-020 IDLE, start=1 with threshold >= PIXEL_MAX_VALUE: go directly to FINISH (zero indexes emitted).
REQ-021 SCAN: one pixel per cycle; if latched pixel[pid]==level go EMIT; else if pid==IMAGE_SIZE-1 go NEXT_LEVEL; else pid++.
REQ-022 EMIT: idx_valid=1, idx_data=pid, both stable until idx_ready=1; transfer occurs on the cycle idx_valid&idx_ready.
REQ-023 On transfer: spike_count++; if new count==IMAGE_SIZE go FINISH; else if pid==IMAGE_SIZE-1 go NEXT_LEVEL; else pid++, go SCAN.
REQ-024 NEXT_LEVEL: if level is final (threshold when descending, PIXEL_MAX_VALUE-1 when ascending) go FINISH; else level -/+ 1 per mode, pid=0, go SCAN.
REQ-025 FINISH: done=1 for exactly one cycle, busy=0, next state IDLE; spike_count holds until next accepted start.
REQ-026 Equal-intensity pixels are emitted in increasing index order in both modes.
REQ-027 Pixels with value >= PIXEL_MAX_VALUE or below threshold are never emitted.
REQ-028 abort=1 in any non-IDLE state: next cycle IDLE, idx_valid=0, done not pulsed, spike_count holds; abort has priority over transfer in the same cycle.
REQ-029 start while busy is ignored; start and abort together in IDLE: abort ignored, start accepted.
REQ-030 Level and pid counters never wrap: the final-level and last-pixel checks occur before any increment/decrement.
REQ-031 With idx_ready held 1, worst-case latency start-to-done = 1 + PIXEL_MAX_VALUE*(IMAGE_SIZE+1) + IMAGE_SIZE + 1 cycles.

Reset
REQ-032 RST=1 at a clock edge: state=IDLE, idx_valid=0, idx_data=0, busy=0, done=0, spike_count=0, internal level/pid/mode/threshold/image registers cleared; applies mid-encode identically.

Structure
REQ-033 Package rank_encoder_pkg holds the state_t enum; width parameters are derived in the module.
REQ-034 Single module, no sub-module; combinational outputs busy/idx_valid decode from state only.

Verification
REQ-035 image={3,9,9,0,5}, descending, threshold=0, ready=1 -> indexes 1,2,4,0,3, done pulse, spike_count=5.
REQ-036 Same image, ascending, threshold=0 -> indexes 3,0,4,1,2, spike_count=5.
REQ-037 Same image, descending, threshold=4 -> indexes 1,2,4 then done, spike_count=3; threshold=10 -> done within 2 cycles, count 0.
REQ-038 idx_ready toggled randomly -> idx_data stable while idx_valid&!idx_ready, sequence unchanged versus REQ-035.
REQ-039 abort asserted after second transfer -> IDLE next cycle, no done, spike_count=2; subsequent start runs a full encode.
REQ-040 RST asserted mid-EMIT -> all outputs at reset values next cycle; start while busy has no effect.
